// File: rtl/melody_player.sv
// melody_player: steps through a fixed note ROM on beat edges and drives a square-wave tone
//   clk_5MHz  in   5 MHz system clock
//   rst       in   synchronous active-high reset
//   beat_clk  in   slow beat square wave, one step per rising edge
//   select    in   1 = play, 0 = pause
//   beep      out  square-wave tone, half-period from the current note
//   note_idx  out  current melody step
//   playing   out  1 while select=1 and the current step is not a rest
module melody_player #(
   parameter int LAST_STEP = 31
) (
   input  logic       clk_5MHz,
   input  logic       rst,
   input  logic       beat_clk,
   input  logic       select,
   output logic       beep,
   output logic [4:0] note_idx,
   output logic       playing
);
   localparam logic [3:0] NOTES [32] = '{
      4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd0,
      4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0,
      4'd5, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd0,
      4'd5, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd0
   };
   function automatic logic [13:0] hp_of(input logic [3:0] c);
      case (c)
         4'd1:    hp_of = 14'd9556;
         4'd2:    hp_of = 14'd8513;
         4'd3:    hp_of = 14'd7584;
         4'd4:    hp_of = 14'd7159;
         4'd5:    hp_of = 14'd6378;
         4'd6:    hp_of = 14'd5682;
         4'd7:    hp_of = 14'd5062;
         4'd8:    hp_of = 14'd4778;
         4'd9:    hp_of = 14'd4257;
         4'd10:   hp_of = 14'd3792;
         4'd11:   hp_of = 14'd3580;
         4'd12:   hp_of = 14'd3189;
         4'd13:   hp_of = 14'd2841;
         4'd14:   hp_of = 14'd2531;
         default: hp_of = 14'd0;
      endcase
   endfunction
   function automatic logic is_rest(input logic [3:0] c);
      return (c == 4'd0) || (c == 4'd15);
   endfunction
   logic        r_beat_q;
   logic        r_beep;
   logic        r_playing;
   logic [4:0]  r_note_idx;
   logic [13:0] r_cnt;
   logic [3:0]  w_code;
   logic [13:0] w_hp;
   logic        w_adv;
   logic [4:0]  w_idx_nxt;
   assign w_code    = NOTES[r_note_idx];
   assign w_hp      = hp_of(w_code);
   assign w_adv     = beat_clk & ~r_beat_q & select;
   assign w_idx_nxt = !w_adv ? r_note_idx : (r_note_idx == 5'(LAST_STEP)) ? 5'd0 : r_note_idx + 5'd1;
   always_ff @(posedge clk_5MHz) begin
      if (rst) begin
         r_beat_q   <= 1'b0;
         r_beep     <= 1'b0;
         r_playing  <= 1'b0;
         r_note_idx <= 5'd0;
         r_cnt      <= 14'd0;
      end else begin
         r_beat_q   <= beat_clk;
         r_note_idx <= w_idx_nxt;
         // playing follows the step being entered so it lines up with note_idx
         r_playing  <= select & ~is_rest(NOTES[w_idx_nxt]);
         if (!select) begin
            r_cnt  <= 14'd0;
            r_beep <= 1'b0;
         end else if (w_adv) begin
            // restart the tone period on a new step; beep level carries over
            r_cnt  <= 14'd0;
         end else if (is_rest(w_code)) begin
            r_cnt  <= 14'd0;
            r_beep <= 1'b0;
         end else if (r_cnt == w_hp - 14'd1) begin
            r_cnt  <= 14'd0;
            r_beep <= ~r_beep;
         end else begin
            r_cnt  <= r_cnt + 14'd1;
         end
      end
   end
   assign beep     = r_beep;
   assign note_idx = r_note_idx;
   assign playing  = r_playing;
endmodule
